// File: rtl/demod_pkg.sv
// Shared definitions for the conjugate-multiply demodulator: channel index
// width, wide I/Q accumulator pair and the round/reduce helper.
// Optional feature: DEMOD_SAT_EN selects saturation instead of wrap when the
// shifted result is reduced to the output width.
package demod_pkg;

  // Channel tag width carried alongside each beat (up to 16 channels).
  localparam int CH_W = 4;

  // Working width for rounding/reduction; wide enough for 2*IN_W+1 sums
  // plus the rounding constant for any supported IN_W up to 32.
  localparam int ACC_W = 72;

  // One I/Q component pair held at the working width.
  typedef struct packed {
    logic signed [ACC_W-1:0] im;
    logic signed [ACC_W-1:0] re;
  } iq_acc_t;

  // Round half up by 'shift' bits, then reduce to 'out_w' bits
  // (saturating or wrapping). Result is sign-extended back to ACC_W.
  function automatic logic signed [ACC_W-1:0] round_reduce(
    input logic signed [ACC_W-1:0] val,
    input int                      shift,
    input int                      out_w
  );
    logic signed [ACC_W-1:0] r;
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    r = val;
    if (shift > 0) begin
      r = r + (ACC_W'(1) <<< (shift - 1));
    end
    r = r >>> shift;
`ifdef DEMOD_SAT_EN
    hi = (ACC_W'(1) <<< (out_w - 1)) - ACC_W'(1);
    lo = -(ACC_W'(1) <<< (out_w - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
`else
    // Keep only the low out_w bits, sign-extended (two's complement wrap).
    hi = r <<< (ACC_W - out_w);
    lo = hi >>> (ACC_W - out_w);
    r  = lo;
`endif
    return r;
  endfunction

endpackage

// File: rtl/conj_mult_stage.sv
// Two-stage complex multiply cur*conj(prev): stage 1 registers the four
// partial products, stage 2 forms the sums, rounds and reduces to OUT_W.
// Both stages advance together on 'en'; bubbles travel with valid=0.
// Reduction mode follows DEMOD_SAT_EN (see demod_pkg).
module conj_mult_stage
  import demod_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 0
)(
  input  logic                    s00_axis_aclk,
  input  logic                    s00_axis_areset,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [CH_W-1:0]         in_ch,
  input  logic signed [IN_W-1:0]  cur_re,
  input  logic signed [IN_W-1:0]  cur_im,
  input  logic signed [IN_W-1:0]  prev_re,
  input  logic signed [IN_W-1:0]  prev_im,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [CH_W-1:0]         out_ch,
  output logic signed [OUT_W-1:0] out_re,
  output logic signed [OUT_W-1:0] out_im
);

  localparam int PROD_W = 2 * IN_W;
  localparam int SUM_W  = PROD_W + 1;

  logic signed [PROD_W-1:0] p_rr_reg, p_ii_reg, p_ir_reg, p_ri_reg;
  logic                     s1_valid_reg, s1_last_reg;
  logic [CH_W-1:0]          s1_ch_reg;
  logic signed [SUM_W-1:0]  re_sum, im_sum;
  iq_acc_t                  sum_acc;

  // Stage 1: full-precision partial products plus beat tags.
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      p_rr_reg     <= '0;
      p_ii_reg     <= '0;
      p_ir_reg     <= '0;
      p_ri_reg     <= '0;
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_ch_reg    <= '0;
    end else if (en) begin
      p_rr_reg     <= PROD_W'(cur_re) * PROD_W'(prev_re);
      p_ii_reg     <= PROD_W'(cur_im) * PROD_W'(prev_im);
      p_ir_reg     <= PROD_W'(cur_im) * PROD_W'(prev_re);
      p_ri_reg     <= PROD_W'(cur_re) * PROD_W'(prev_im);
      s1_valid_reg <= in_valid;
      s1_last_reg  <= in_last;
      s1_ch_reg    <= in_ch;
    end
  end

  // Sums at one bit wider than the products so they cannot overflow.
  assign re_sum = SUM_W'(p_rr_reg) + SUM_W'(p_ii_reg);
  assign im_sum = SUM_W'(p_ir_reg) - SUM_W'(p_ri_reg);

  // Sign-extend the sums to the working width for rounding.
  always_comb begin
    sum_acc    = '0;
    sum_acc.re = ACC_W'(re_sum);
    sum_acc.im = ACC_W'(im_sum);
  end

  // Stage 2: round, reduce and register the output beat.
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_ch    <= '0;
      out_re    <= '0;
      out_im    <= '0;
    end else if (en) begin
      out_valid <= s1_valid_reg;
      out_last  <= s1_last_reg;
      out_ch    <= s1_ch_reg;
      out_re    <= OUT_W'(round_reduce(sum_acc.re, SHIFT, OUT_W));
      out_im    <= OUT_W'(round_reduce(sum_acc.im, SHIFT, OUT_W));
    end
  end

endmodule

// File: rtl/demod_conj_mc.sv
// Multi-channel conjugate-multiply demodulator: out = cur * conj(prev) per
// time-interleaved channel, AXI-Stream in/out with 2-cycle latency.
// Define DEMOD_SAT_EN to saturate results to OUT_W instead of wrapping.
module demod_conj_mc
  import demod_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int NUM_CH = 1,
  parameter int SHIFT  = 0
)(
  input  logic                 s00_axis_aclk,
  input  logic                 s00_axis_areset,
  input  logic                 s00_axis_tvalid,
  output logic                 s00_axis_tready,
  input  logic [2*IN_W-1:0]    s00_axis_tdata,
  input  logic                 s00_axis_tlast,
  output logic                 m00_axis_tvalid,
  input  logic                 m00_axis_tready,
  output logic [2*OUT_W-1:0]   m00_axis_tdata,
  output logic                 m00_axis_tlast,
  output logic [3:0]           m00_axis_tuser
);

  logic                    en, accept;
  logic [CH_W-1:0]         ch_cnt_reg;
  logic signed [IN_W-1:0]  cur_re, cur_im, prev_re, prev_im;
  logic signed [IN_W-1:0]  prev_re_ch [NUM_CH];
  logic signed [IN_W-1:0]  prev_im_ch [NUM_CH];
  logic signed [OUT_W-1:0] out_re, out_im;

  // Whole pipeline stalls together; a free output slot frees the input.
  assign en              = ~m00_axis_tvalid | m00_axis_tready;
  assign s00_axis_tready = en;
  assign accept          = s00_axis_tvalid & en;

  assign cur_re = s00_axis_tdata[IN_W-1:0];
  assign cur_im = s00_axis_tdata[2*IN_W-1:IN_W];

  // Round-robin channel counter; tlast resynchronises to channel 0.
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      ch_cnt_reg <= '0;
    end else if (accept) begin
      if (s00_axis_tlast || ch_cnt_reg == CH_W'(NUM_CH - 1)) begin
        ch_cnt_reg <= '0;
      end else begin
        ch_cnt_reg <= ch_cnt_reg + 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic signed [IN_W-1:0] hist_re_reg, hist_im_reg;
      logic                   primed_reg;

      // Per-channel history; only an accepted beat of this channel updates it.
      always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
          hist_re_reg <= '0;
          hist_im_reg <= '0;
          primed_reg  <= 1'b0;
        end else if (accept && ch_cnt_reg == CH_W'(gi)) begin
          hist_re_reg <= cur_re;
          hist_im_reg <= cur_im;
          primed_reg  <= 1'b1;
        end
      end

      // An unprimed channel presents a zero reference, so its first product is 0.
      assign prev_re_ch[gi] = primed_reg ? hist_re_reg : '0;
      assign prev_im_ch[gi] = primed_reg ? hist_im_reg : '0;
    end
  endgenerate

  // Select the reference sample of the channel owning the current beat.
  always_comb begin
    prev_re = '0;
    prev_im = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_cnt_reg == CH_W'(i)) begin
        prev_re = prev_re_ch[i];
        prev_im = prev_im_ch[i];
      end
    end
  end

  conj_mult_stage #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_mult (
    .s00_axis_aclk   (s00_axis_aclk),
    .s00_axis_areset (s00_axis_areset),
    .en              (en),
    .in_valid        (accept),
    .in_last         (s00_axis_tlast),
    .in_ch           (ch_cnt_reg),
    .cur_re          (cur_re),
    .cur_im          (cur_im),
    .prev_re         (prev_re),
    .prev_im         (prev_im),
    .out_valid       (m00_axis_tvalid),
    .out_last        (m00_axis_tlast),
    .out_ch          (m00_axis_tuser),
    .out_re          (out_re),
    .out_im          (out_im)
  );

  assign m00_axis_tdata = {out_im, out_re};

endmodule
